transmitter: RTL and testbench

//  UART transmit half of the serial port; the counterpart of receiver on the same brg_en tick.
//  CPU writes a byte over the IOCS/IORW bus into a one-byte holding buffer.
//  The block serialises it on TX as start(0), 8 data bits LSB first, stop(1).
//  TBR tells the CPU when the holding buffer can take the next byte.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tick_div.sv | 29 ++
 rtl/transmitter.sv | 115 +++++++++++
 tb/tb_transmitter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame line levels, bus direction encoding and FSM states.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BITCNT_W  = 3;

  localparam logic START_LVL  = 1'b0;
  localparam logic STOP_LVL   = 1'b1;
  localparam logic IORW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tick_div.sv
// Divides brg_en pulses down to one bit_tick every BRG_DIV pulses; clr holds the phase at zero.
module uart_tick_div #(
  parameter int unsigned BRG_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic brg_en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (BRG_DIV > 1) ? $clog2(BRG_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BRG_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (brg_en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick_c = brg_en && (cnt == LAST);

endmodule

// File: rtl/transmitter.sv
// UART transmitter: one-byte holding buffer loaded from the CPU bus, serialised as start/8N/stop.
module transmitter
  import uart_pkg::*;
#(
  parameter int unsigned BRG_DIV   = 1,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 brg_en,
  input  logic                 IOCS,
  input  logic                 IORW,
  inout  wire  [DATA_BITS-1:0] DATABUS,
  output logic                 TX,
  output logic                 TBR,
  output logic                 BUSY
);

  uart_state_e          state;
  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS-1:0] shifter;
  logic [BITCNT_W-1:0]  bitcnt;
  logic                 wr_c;
  logic                 bit_tick_c;
  logic                 div_clr_c;

  // The transmitter never drives the shared bus.
  assign DATABUS = {DATA_BITS{1'bz}};

  assign wr_c      = IOCS && (IORW == IORW_WRITE);
  assign div_clr_c = (state == ST_IDLE);

  uart_tick_div #(
    .BRG_DIV (BRG_DIV)
  ) u_tick_div (
    .clk    (clk),
    .rst_n  (rst),
    .brg_en (brg_en),
    .clr    (div_clr_c),
    .tick_c (bit_tick_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      hold    <= '0;
      shifter <= '0;
      bitcnt  <= '0;
      TX      <= STOP_LVL;
      TBR     <= 1'b1;
      BUSY    <= 1'b0;
    end else begin
      // Bus write only lands while the holding buffer is empty; the transfer below
      // can only coincide with TBR=0, so its TBR<=1 never races an accepted write.
      if (wr_c && TBR) begin
        hold <= DATABUS;
        TBR  <= 1'b0;
      end

      unique case (state)
        ST_IDLE: begin
          TX   <= STOP_LVL;
          BUSY <= 1'b0;
          // The divider is held clear while idle, so any brg_en is a frame boundary.
          if (brg_en && !TBR) begin
            shifter <= hold;
            TBR     <= 1'b1;
            TX      <= START_LVL;
            BUSY    <= 1'b1;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_tick_c) begin
            TX     <= shifter[0];
            bitcnt <= '0;
            state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_tick_c) begin
            if (bitcnt == BITCNT_W'(DATA_BITS - 1)) begin
              TX    <= STOP_LVL;
              state <= ST_STOP;
            end else begin
              shifter <= shifter >> 1;
              TX      <= shifter[1];
              bitcnt  <= bitcnt + BITCNT_W'(1);
            end
          end
        end
        ST_STOP: begin
          if (bit_tick_c) begin
            // A byte queued during this frame follows with no idle bit in between.
            if (!TBR) begin
              shifter <= hold;
              TBR     <= 1'b1;
              TX      <= START_LVL;
              state   <= ST_START;
            end else begin
              BUSY  <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          TX    <= STOP_LVL;
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transmitter.sv
// Self-checking bench for transmitter: frames decoded from TX samples per brg_en tick.
module tb_transmitter;

  logic       clk;
  logic       rst;
  logic       brg_en;
  logic       iocs1;
  logic       iocs4;
  logic       iorw;
  logic       drv;
  logic [7:0] dat;
  wire  [7:0] DATABUS;
  logic       tx1, tbr1, busy1;
  logic       tx4, tbr4, busy4;

  int ncomp = 0;
  int nfail = 0;

  logic       q1[$];
  logic       q4[$];
  logic [7:0] exp_q[$];
  int         busy_cnt1 = 0;
  int         busy_cnt4 = 0;
  logic       tick_pend = 1'b0;

  assign DATABUS = drv ? dat : 8'bz;

  transmitter #(.BRG_DIV(1), .DATA_BITS(8)) dut1 (
    .clk(clk), .rst(rst), .brg_en(brg_en), .IOCS(iocs1), .IORW(iorw),
    .DATABUS(DATABUS), .TX(tx1), .TBR(tbr1), .BUSY(busy1)
  );

  transmitter #(.BRG_DIV(4), .DATA_BITS(8)) dut4 (
    .clk(clk), .rst(rst), .brg_en(brg_en), .IOCS(iocs4), .IORW(iorw),
    .DATABUS(DATABUS), .TX(tx4), .TBR(tbr4), .BUSY(busy4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-clock baud pulse every 9 clocks.
  initial begin
    brg_en = 1'b0;
    forever begin
      repeat (8) @(posedge clk);
      #1 brg_en = 1'b1;
      @(posedge clk);
      #1 brg_en = 1'b0;
    end
  end

  // Line sample taken one clock after each brg_en pulse, plus BUSY duration counters.
  always @(negedge clk) begin
    if (tick_pend) begin
      q1.push_back(tx1);
      q4.push_back(tx4);
    end
    tick_pend = brg_en;
    if (busy1) busy_cnt1 = busy_cnt1 + 1;
    if (busy4) busy_cnt4 = busy_cnt4 + 1;
  end

  function automatic logic [9:0] frame10(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    ncomp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic start_rec();
    q1.delete();
    q4.delete();
    exp_q.delete();
    busy_cnt1 = 0;
    busy_cnt4 = 0;
  endtask

  task automatic write_byte(input bit to4, input logic [7:0] b);
    @(posedge clk);
    #1;
    iorw = 1'b0;
    dat  = b;
    drv  = 1'b1;
    if (to4) iocs4 = 1'b1;
    else     iocs1 = 1'b1;
    @(posedge clk);
    #1;
    iocs1 = 1'b0;
    iocs4 = 1'b0;
    drv   = 1'b0;
    iorw  = 1'b1;
  endtask

  task automatic wait_busy1(input string tag);
    int n = 0;
    while (!busy1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      ncomp++;
      nfail++;
      $error("FAIL %s_busy_timeout: observed busy=%0b expected 1", tag, busy1);
    end
  endtask

  task automatic wait_idle(input bit d4, input string tag);
    int n = 0;
    while ((d4 ? (busy4 || !tbr4) : (busy1 || !tbr1)) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      ncomp++;
      nfail++;
      $error("FAIL %s_idle_timeout: observed still busy expected idle", tag);
    end
    repeat (40) @(negedge clk);
  endtask

  // Decode queued frames for the BRG_DIV=1 instance against exp_q.
  task automatic decode1(input bit b2b, input string tag);
    int idx = 0;
    int gap;
    logic [9:0] got;
    logic ok;
    for (int f = 0; f < exp_q.size(); f++) begin
      gap = 0;
      while (idx < q1.size() && q1[idx] == 1'b1) begin
        idx++;
        gap++;
      end
      if (f > 0 && b2b) chk({tag, "_gap"}, 64'(gap), 64'd0);
      if (idx + 10 > q1.size()) begin
        ncomp++;
        nfail++;
        $error("FAIL %s_short: observed %0d samples expected 10", tag, q1.size() - idx);
        return;
      end
      got = '0;
      for (int i = 0; i < 10; i++) got[i] = q1[idx + i];
      idx += 10;
      chk({tag, "_frame"}, 64'(got), 64'(frame10(exp_q[f])));
    end
    ok = 1'b1;
    for (int i = idx; i < q1.size(); i++) if (q1[i] !== 1'b1) ok = 1'b0;
    chk({tag, "_idle_tail"}, 64'(ok), 64'd1);
  endtask

  // Each frame bit of the BRG_DIV=4 instance must hold for exactly four samples.
  task automatic decode4(input logic [7:0] b, input string tag);
    int idx = 0;
    logic [9:0]  fr;
    logic [39:0] got;
    logic [39:0] expv;
    while (idx < q4.size() && q4[idx] == 1'b1) idx++;
    if (idx + 40 > q4.size()) begin
      ncomp++;
      nfail++;
      $error("FAIL %s_short: observed %0d samples expected 40", tag, q4.size() - idx);
      return;
    end
    fr = frame10(b);
    for (int i = 0; i < 40; i++) begin
      got[i]  = q4[idx + i];
      expv[i] = fr[i / 4];
    end
    chk({tag, "_frame40"}, 64'(got), 64'(expv));
    chk({tag, "_after"}, 64'((idx + 40 < q4.size()) ? q4[idx + 40] : 1'b0), 64'd1);
  endtask

  task automatic single_frame(input logic [7:0] b, input string tag);
    start_rec();
    exp_q.push_back(b);
    write_byte(1'b0, b);
    chk({tag, "_tbr_wr"}, 64'(tbr1), 64'd0);
    wait_busy1(tag);
    chk({tag, "_tbr_load"}, 64'(tbr1), 64'd1);
    chk({tag, "_tx_start"}, 64'(tx1), 64'd0);
    wait_idle(1'b0, tag);
    decode1(1'b0, tag);
    chk({tag, "_busy_len"}, 64'(busy_cnt1), 64'd90);
  endtask

  task automatic pair_frames(input logic [7:0] a, input logic [7:0] b, input string tag);
    start_rec();
    exp_q.push_back(a);
    exp_q.push_back(b);
    write_byte(1'b0, a);
    wait_busy1(tag);
    repeat (20) @(negedge clk);
    write_byte(1'b0, b);
    chk({tag, "_tbr_queued"}, 64'(tbr1), 64'd0);
    wait_idle(1'b0, tag);
    decode1(1'b1, tag);
    chk({tag, "_busy_len"}, 64'(busy_cnt1), 64'd180);
  endtask

  logic [7:0] rb;
  logic [7:0] rb2;

  initial begin
    rst   = 1'b1;
    iocs1 = 1'b0;
    iocs4 = 1'b0;
    iorw  = 1'b1;
    drv   = 1'b0;
    dat   = 8'h00;

    #2 rst = 1'b0;
    #1;
    chk("rst_tx", 64'(tx1), 64'd1);
    chk("rst_tbr", 64'(tbr1), 64'd1);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_tx4", 64'(tx4), 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    single_frame(8'hA5, "a5");
    for (int k = 0; k < 4; k++) begin
      rb = 8'($urandom);
      single_frame(rb, "rand_single");
    end

    pair_frames(8'h1A, 8'hFF, "b2b");
    for (int k = 0; k < 2; k++) begin
      rb  = 8'($urandom);
      rb2 = 8'($urandom);
      pair_frames(rb, rb2, "rand_b2b");
    end

    // Second write while buffer full is dropped.
    start_rec();
    exp_q.push_back(8'h11);
    write_byte(1'b0, 8'h11);
    write_byte(1'b0, 8'h22);
    chk("drop_tbr", 64'(tbr1), 64'd0);
    wait_busy1("drop");
    chk("drop_tbr_load", 64'(tbr1), 64'd1);
    wait_idle(1'b0, "drop");
    decode1(1'b0, "drop");
    chk("drop_busy_len", 64'(busy_cnt1), 64'd90);

    // BRG_DIV=4 instance.
    start_rec();
    write_byte(1'b1, 8'h3C);
    chk("div4_tbr_wr", 64'(tbr4), 64'd0);
    wait_idle(1'b1, "div4");
    decode4(8'h3C, "div4");
    chk("div4_busy_len", 64'(busy_cnt4), 64'd360);
    rb = 8'($urandom);
    start_rec();
    write_byte(1'b1, rb);
    wait_idle(1'b1, "div4r");
    decode4(rb, "div4r");
    chk("div4r_busy_len", 64'(busy_cnt4), 64'd360);

    // Asynchronous reset mid-frame discards both the frame and the queued byte.
    start_rec();
    write_byte(1'b0, 8'h00);
    wait_busy1("midrst");
    repeat (30) @(negedge clk);
    chk("midrst_tx_low", 64'(tx1), 64'd0);
    write_byte(1'b0, 8'h5A);
    chk("midrst_queued", 64'(tbr1), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_tx", 64'(tx1), 64'd1);
    chk("midrst_tbr", 64'(tbr1), 64'd1);
    chk("midrst_busy", 64'(busy1), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    start_rec();
    repeat (200) @(negedge clk);
    chk("midrst_no_busy", 64'(busy_cnt1), 64'd0);
    decode1(1'b0, "midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
